// File: rtl/btn_event_pkg.sv
// ============================================================================
// Module : btn_event_pkg
// Brief  : Shared state encoding and timer sizing for the button event decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package btn_event_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_t;

    // One spare bit above clog2 so the counter can reach either threshold
    // and still have headroom before saturating.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/event_timer.sv
// ============================================================================
// Module : event_timer
// Brief  : Saturating up-counter with synchronous clear, async active-low reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module event_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
// ============================================================================
// Module : button_event_decoder
// Brief  : Classifies a debounced button level into short/long/double pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_event_decoder #(
    parameter int LONG_CYCLES       = 1000,
    parameter int DOUBLE_GAP_CYCLES = 300,
    parameter int CNT_W             = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clean,
    output logic             short_press,
    output logic             long_press,
    output logic             double_press,
    output logic             held,
    output logic [CNT_W-1:0] press_count
);

    import btn_event_pkg::*;

    localparam int TIMER_W = timer_width(LONG_CYCLES, DOUBLE_GAP_CYCLES);

    // The timer is cleared on the edge that enters a state, and that edge is
    // itself the first sample of the run, so the N-th sample sees timer == N-2.
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYCLES - 2);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(DOUBLE_GAP_CYCLES - 2);

    state_t               state;
    state_t               state_next;
    logic                 clean_q;
    logic                 rise;
    logic                 fall;
    logic                 timer_clear;
    logic [TIMER_W-1:0]   timer;
    logic                 short_next;
    logic                 long_next;
    logic                 double_next;
    logic                 held_next;

    assign rise        = clean & ~clean_q;
    assign fall        = ~clean & clean_q;
    assign timer_clear = (state_next != state);

    event_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .count   (timer)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        short_next  = 1'b0;
        long_next   = 1'b0;
        double_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (clean && (timer == LONG_LAST)) begin
                    long_next  = 1'b1;
                    state_next = LONG_HELD;
                end else if (fall) begin
                    state_next = WAIT_SECOND;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_next = IDLE;
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_next = SECOND_PRESSED;
                end else if (!clean && (timer == GAP_LAST)) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    double_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign held_next = (state_next == PRESSED) ||
                       (state_next == LONG_HELD) ||
                       (state_next == SECOND_PRESSED);

    // clean_q resets high so a button held through reset must be released first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clean_q      <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
            press_count  <= '0;
        end else begin
            clean_q      <= clean;
            short_press  <= short_next;
            long_press   <= long_next;
            double_press <= double_next;
            held         <= held_next;
            if (short_next || long_next || double_next) begin
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_button_event_decoder.sv
// ============================================================================
// Module : tb_button_event_decoder
// Brief  : Randomised scoreboard bench with a run-length reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_event_decoder;

    localparam int L  = 10;
    localparam int G  = 5;
    localparam int CW = 3;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b1;
    logic          clean   = 1'b0;
    logic          short_press;
    logic          long_press;
    logic          double_press;
    logic          held;
    logic [CW-1:0] press_count;

    button_event_decoder #(
        .LONG_CYCLES       (L),
        .DOUBLE_GAP_CYCLES (G),
        .CNT_W             (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clean        (clean),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .held         (held),
        .press_count  (press_count)
    );

    always #5 clock = ~clock;

    typedef struct {int due; int kind; int cnt;} ev_t;
    typedef struct {int due; int hld;  int cnt;} st_t;

    ev_t evq[$];
    st_t hq[$];

    int cycle  = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: tracks run lengths of the sampled level and the press
    // bookkeeping (active press, second of a pair, long already fired, gap open).
    bit m_prev   = 1'b1;
    bit m_active = 1'b0;
    bit m_second = 1'b0;
    bit m_long   = 1'b0;
    bit m_open   = 1'b0;
    int m_run    = 0;
    int m_cnt    = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic sample(input bit c);
        int ev;
        ev    = 0;
        clean = c;
        if (c == m_prev) m_run++;
        else             m_run = 1;
        if (c && !m_prev) begin
            m_second = m_open;
            m_open   = 1'b0;
            m_active = 1'b1;
            m_long   = 1'b0;
        end else if (!c && m_prev && m_active) begin
            m_active = 1'b0;
            if (m_second)     ev = 3;
            else if (!m_long) m_open = 1'b1;
        end else if (c && m_active && !m_second && !m_long && m_run == L) begin
            ev     = 2;
            m_long = 1'b1;
        end else if (!c && m_open && m_run == G) begin
            ev     = 1;
            m_open = 1'b0;
        end
        if (ev != 0) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            evq.push_back('{cycle + 1, ev, m_cnt});
        end
        hq.push_back('{cycle + 1, int'(m_active), m_cnt});
        m_prev = c;
    endtask

    task automatic steps(input bit c, input int n);
        repeat (n) begin
            @(negedge clock);
            sample(c);
        end
    endtask

    // Reset lands mid-cycle so the asynchronous clear is observed directly.
    task automatic do_reset(input bit c);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        clean   = c;
        #1;
        chk("rst_short",  32'(short_press),  0);
        chk("rst_long",   32'(long_press),   0);
        chk("rst_double", 32'(double_press), 0);
        chk("rst_held",   32'(held),         0);
        chk("rst_count",  32'(press_count),  0);
        evq.delete();
        hq.delete();
        m_prev = 1'b1; m_active = 1'b0; m_second = 1'b0;
        m_long = 1'b0; m_open = 1'b0; m_run = 0; m_cnt = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        sample(c);
    endtask

    int  np;
    int  kind;
    ev_t e;
    st_t s;

    always @(negedge clock) begin
        if (mon_en && reset_n) begin
            np = int'(short_press) + int'(long_press) + int'(double_press);
            if (np > 0) begin
                chk("pulses_per_cycle", 32'(np), 1);
                kind = short_press ? 1 : (long_press ? 2 : 3);
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", 32'(kind), 0);
                end else begin
                    e = evq.pop_front();
                    chk("event_cycle", 32'(cycle), 32'(e.due));
                    chk("event_kind",  32'(kind),  32'(e.kind));
                    chk("event_count", 32'(press_count), 32'(e.cnt));
                end
            end else if (evq.size() != 0 && evq[0].due <= cycle) begin
                e = evq.pop_front();
                chk("missed_event_kind", 32'(np), 32'(e.kind));
            end
            if (hq.size() != 0 && hq[0].due == cycle) begin
                s = hq.pop_front();
                chk("held",  32'(held),        32'(s.hld));
                chk("count", 32'(press_count), 32'(s.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required<100000", cycle);
        $fatal(1);
    end

    initial begin
        // Short press
        do_reset(1'b0);
        steps(1'b1, 4); steps(1'b0, 8);
        chk("t1_count", 32'(press_count), 1);

        // Long press fires while held, nothing on release
        do_reset(1'b0);
        steps(1'b0, 2); steps(1'b1, 15); steps(1'b0, 3);
        chk("t2_count", 32'(press_count), 1);

        // Double press
        do_reset(1'b0);
        steps(1'b1, 3); steps(1'b0, 2); steps(1'b1, 3); steps(1'b0, 8);
        chk("t3_count", 32'(press_count), 1);

        // Button held through reset is ignored until pressed again
        do_reset(1'b1);
        steps(1'b1, 20); steps(1'b0, 3); steps(1'b1, 12); steps(1'b0, 3);
        chk("t4_count", 32'(press_count), 1);

        // Counter wrap over nine short presses
        do_reset(1'b0);
        repeat (9) begin
            steps(1'b1, 2); steps(1'b0, 6);
        end
        chk("t5_count", 32'(press_count), 1);

        // Reset inside the double-press window discards the pending short
        do_reset(1'b0);
        steps(1'b1, 3); steps(1'b0, 2);
        do_reset(1'b0);
        steps(1'b0, 10);
        chk("t6_count", 32'(press_count), 0);

        // Random activity around both thresholds, with occasional resets
        do_reset(1'b0);
        repeat (60) begin
            if ($urandom_range(0, 15) == 0) do_reset(1'($urandom_range(0, 1)));
            steps(1'b1, int'($urandom_range(1, 14)));
            steps(1'b0, int'($urandom_range(1, 8)));
        end
        steps(1'b0, 14);
        chk("events_drained", 32'(evq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
